any1_picn: RTL and testbench

- Parametrised successor to the fixed 31-input interrupt controller used in the MPU.
- Provides NSRC interrupt sources, each with its own programmable priority level and cause code.
- Each source is individually edge- or level-sensitive.
- Sits on the MPU's registered 32-bit peripheral bus beside the PIT and drives the CPU's irq and cause inputs.

---
 rtl/any1_picn_pkg.sv | 48 ++++
 rtl/any1_picn_arb.sv | 59 +++++
 rtl/any1_picn.sv | 176 +++++++++++++++++
 tb/tb_any1_picn.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/any1_picn_pkg.sv
// any1_picn_pkg: shared definitions for the any1_picn interrupt controller.
// Holds register offsets, CUR field positions, the config word layout and
// a byte-lane merge helper for the 32-bit peripheral bus.
package any1_picn_pkg;

    // Register byte offsets
    localparam logic [7:0] ADR_PEND = 8'h00;
    localparam logic [7:0] ADR_ENAB = 8'h04;
    localparam logic [7:0] ADR_EDGE = 8'h08;
    localparam logic [7:0] ADR_CLR  = 8'h0C;
    localparam logic [7:0] ADR_CUR  = 8'h10;
    localparam logic [7:0] ADR_CFG  = 8'h80;

    // CUR register field positions
    localparam int unsigned CUR_VALID_BIT = 31;
    localparam int unsigned CUR_NMI_BIT   = 30;
    localparam int unsigned CUR_LVL_LSB   = 24;
    localparam int unsigned CUR_LVL_W     = 4;
    localparam int unsigned CUR_CAUSE_LSB = 16;
    localparam int unsigned CUR_CAUSE_W   = 8;
    localparam int unsigned CUR_IDX_LSB   = 0;
    localparam int unsigned CUR_IDX_W     = 5;

    // Per-source config word as it appears on the bus
    typedef struct packed {
        logic [23:0] cause;
        logic [7:0]  level;
    } picn_cfg_t;

    // Expand byte selects into a 32-bit lane mask
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    // Replace only the selected byte lanes of old with wdat
    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = byte_mask(sel);
        return (old & ~m) | (wdat & m);
    endfunction

endpackage

// File: rtl/any1_picn_arb.sv
// any1_picn_arb: combinational priority resolver.
// Picks the highest level among candidates; lowest index wins on ties.
// Built as a binary reduction tree, one generate level per tree stage.
// Ports: cand (candidate mask), levels (flattened per-source levels),
//        valid/index/level (winner).
module any1_picn_arb #(
    parameter int unsigned NSRC = 32,
    parameter int unsigned LVLW = 4,
    parameter int unsigned IDXW = 5
) (
    input  logic [NSRC-1:0]      cand,
    input  logic [NSRC*LVLW-1:0] levels,
    output logic                 valid,
    output logic [IDXW-1:0]      index,
    output logic [LVLW-1:0]      level
);

    localparam int unsigned DEPTH = (NSRC > 1) ? $clog2(NSRC) : 0;
    localparam int unsigned P     = 1 << DEPTH;

    for (genvar k = 0; k <= DEPTH; k++) begin : g_lvl
        localparam int unsigned N = P >> k;
        logic [N-1:0]      v;
        logic [N*LVLW-1:0] l;
        logic [N*IDXW-1:0] ix;

        if (k == 0) begin : g_leaf
            for (genvar j = 0; j < N; j++) begin : g_j
                if (j < NSRC) begin : g_real
                    assign v[j]              = cand[j];
                    assign l[j*LVLW +: LVLW] = levels[j*LVLW +: LVLW];
                end else begin : g_pad
                    assign v[j]              = 1'b0;
                    assign l[j*LVLW +: LVLW] = '0;
                end
                assign ix[j*IDXW +: IDXW] = IDXW'(j);
            end
        end else begin : g_node
            for (genvar j = 0; j < N; j++) begin : g_j
                // Right (higher index) child wins only on a strictly higher level
                logic take_r;
                assign take_r = g_lvl[k-1].v[2*j+1] &&
                                (!g_lvl[k-1].v[2*j] ||
                                 (g_lvl[k-1].l[(2*j+1)*LVLW +: LVLW] >
                                  g_lvl[k-1].l[(2*j)*LVLW +: LVLW]));
                assign v[j] = g_lvl[k-1].v[2*j] | g_lvl[k-1].v[2*j+1];
                assign l[j*LVLW +: LVLW] = take_r ? g_lvl[k-1].l[(2*j+1)*LVLW +: LVLW]
                                                  : g_lvl[k-1].l[(2*j)*LVLW +: LVLW];
                assign ix[j*IDXW +: IDXW] = take_r ? g_lvl[k-1].ix[(2*j+1)*IDXW +: IDXW]
                                                   : g_lvl[k-1].ix[(2*j)*IDXW +: IDXW];
            end
        end
    end

    assign valid = g_lvl[DEPTH].v[0];
    assign level = g_lvl[DEPTH].l[LVLW-1:0];
    assign index = g_lvl[DEPTH].ix[IDXW-1:0];

endmodule

// File: rtl/any1_picn.sv
// any1_picn: parametrised interrupt controller on the 32-bit peripheral bus.
// NSRC sources, each with programmable level/cause and edge/level capture;
// drives the registered winner onto irq_o/cause_o.
// Optional feature macro: ANY1_PICN_NMI_EN (NMI output from nmi_i or any
// all-ones-level candidate; reported in CUR bit 30).
// Ports: clk_i/rst_i (sync, active-high); cs/cyc/stb/we/sel/adr/dat_i and
//        ack_o/dat_o bus; src_i sources; nmi_i; irq_o, cause_o, nmi_o.
module any1_picn
    import any1_picn_pkg::*;
#(
    parameter int unsigned NSRC   = 32,
    parameter int unsigned LVLW   = 4,
    parameter int unsigned CAUSEW = 8,
    parameter int unsigned SYNC   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    output logic              ack_o,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    input  logic [7:0]        adr_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    input  logic [NSRC-1:0]   src_i,
    input  logic              nmi_i,
    output logic [LVLW-1:0]   irq_o,
    output logic [CAUSEW-1:0] cause_o,
    output logic              nmi_o
);

    localparam int unsigned IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0]   s, s_prev, pending, enable, edge_mode, clr_bits, rise, pend_next, cand;
    logic [LVLW-1:0]   lvl_q   [NSRC];
    logic [CAUSEW-1:0] cause_q [NSRC];
    logic [NSRC*LVLW-1:0] lvl_flat;
    logic              cur_valid;
    logic [IDXW-1:0]   cur_index;
    logic              win_v;
    logic [IDXW-1:0]   win_i;
    logic [LVLW-1:0]   win_l;
    logic              acc, wr, hit_pend, hit_enab, hit_edge, hit_clr, hit_cur, hit_cfg;
    logic [5:0]        word_adr;
    logic [IDXW-1:0]   cfg_idx;
    picn_cfg_t         cfg_old, cfg_new;
    logic [31:0]       rdata;
    logic              top_any;
    logic              unused;

    // Optional two-flop synchroniser on the source inputs
    if (SYNC != 0) begin : g_sync
        logic [NSRC-1:0] meta, stab;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                meta <= '0;
                stab <= '0;
            end else begin
                meta <= src_i;
                stab <= meta;
            end
        end
        assign s = stab;
    end else begin : g_nosync
        assign s = src_i;
    end

    // Bus decode; a write lands on the edge that raises ack_o
    always_comb begin
        acc      = cs_i & cyc_i & stb_i & ~ack_o;
        wr       = acc & we_i;
        word_adr = adr_i[7:2];
        hit_pend = (word_adr == ADR_PEND[7:2]);
        hit_enab = (word_adr == ADR_ENAB[7:2]);
        hit_edge = (word_adr == ADR_EDGE[7:2]);
        hit_clr  = (word_adr == ADR_CLR[7:2]);
        hit_cur  = (word_adr == ADR_CUR[7:2]);
        hit_cfg  = (adr_i[7] == ADR_CFG[7]) && (32'(adr_i[6:2]) < NSRC);
        cfg_idx  = IDXW'(adr_i[6:2]);
        clr_bits = (wr && hit_clr) ? NSRC'(dat_i & byte_mask(sel_i)) : '0;
    end

    // Capture: level bits follow s; edge bits set on rise (beats CLR)
    always_comb begin
        rise      = s & ~s_prev;
        pend_next = (edge_mode & ((pending & ~clr_bits) | rise)) | (~edge_mode & s);
        top_any   = 1'b0;
        lvl_flat  = '0;
        cand      = '0;
        for (int n = 0; n < NSRC; n++) begin
            lvl_flat[n*LVLW +: LVLW] = lvl_q[n];
            cand[n] = pending[n] & enable[n] & (lvl_q[n] != '0);
            if (cand[n] && (lvl_q[n] == '1)) top_any = 1'b1;
        end
    end

    any1_picn_arb #(.NSRC(NSRC), .LVLW(LVLW), .IDXW(IDXW)) u_arb (
        .cand   (cand),
        .levels (lvl_flat),
        .valid  (win_v),
        .index  (win_i),
        .level  (win_l)
    );

    // Read mux and config byte-lane merge
    always_comb begin
        rdata         = '0;
        cfg_old.cause = 24'(cause_q[cfg_idx]);
        cfg_old.level = 8'(lvl_q[cfg_idx]);
        cfg_new       = picn_cfg_t'(byte_merge(cfg_old, dat_i, sel_i));
        if (hit_pend)      rdata = 32'(pending);
        else if (hit_enab) rdata = 32'(enable);
        else if (hit_edge) rdata = 32'(edge_mode);
        else if (hit_cur) begin
            rdata[CUR_VALID_BIT]                  = cur_valid;
`ifdef ANY1_PICN_NMI_EN
            rdata[CUR_NMI_BIT]                    = nmi_o;
`endif
            rdata[CUR_LVL_LSB +: CUR_LVL_W]       = CUR_LVL_W'(irq_o);
            rdata[CUR_CAUSE_LSB +: CUR_CAUSE_W]   = CUR_CAUSE_W'(cause_o);
            rdata[CUR_IDX_LSB +: CUR_IDX_W]       = CUR_IDX_W'(cur_index);
        end else if (hit_cfg) rdata = cfg_old;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o     <= 1'b0;
            dat_o     <= '0;
            s_prev    <= '0;
            pending   <= '0;
            enable    <= '0;
            edge_mode <= '0;
            cur_valid <= 1'b0;
            cur_index <= '0;
            irq_o     <= '0;
            cause_o   <= '0;
            nmi_o     <= 1'b0;
            for (int n = 0; n < NSRC; n++) begin
                lvl_q[n]   <= '0;
                cause_q[n] <= '0;
            end
        end else begin
            ack_o   <= acc;
            dat_o   <= (acc && !we_i) ? rdata : '0;
            s_prev  <= s;
            pending <= pend_next;
            if (wr && hit_enab) enable    <= NSRC'(byte_merge(32'(enable), dat_i, sel_i));
            if (wr && hit_edge) edge_mode <= NSRC'(byte_merge(32'(edge_mode), dat_i, sel_i));
            if (wr && hit_cfg) begin
                lvl_q[cfg_idx]   <= LVLW'(cfg_new.level);
                cause_q[cfg_idx] <= CAUSEW'(cfg_new.cause);
            end
            // With no candidate the cause and index of the last winner are held
            cur_valid <= win_v;
            irq_o     <= win_v ? win_l : '0;
            if (win_v) begin
                cause_o   <= cause_q[win_i];
                cur_index <= win_i;
            end
`ifdef ANY1_PICN_NMI_EN
            nmi_o <= nmi_i | top_any;
`else
            nmi_o <= 1'b0;
`endif
        end
    end

`ifdef ANY1_PICN_NMI_EN
    assign unused = ^{adr_i[1:0]};
`else
    assign unused = ^{adr_i[1:0], nmi_i, top_any};
`endif

endmodule

// File: tb/tb_any1_picn.sv
// Scoreboard bench for any1_picn: reads push expected values, a monitor
// pops and compares on each read acknowledge.
module tb_any1_picn;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cs_i = 1'b0, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [7:0]  adr_i = 8'h00;
    logic [31:0] dat_i = 32'h0;
    logic        ack_o;
    logic [31:0] dat_o;
    logic [31:0] src_i = 32'h0;
    logic        nmi_i = 1'b0;
    logic [3:0]  irq_o;
    logic [7:0]  cause_o;
    logic        nmi_o;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_dat_q[$];
    logic [3:0]  exp_irq_q[$];
    logic [7:0]  exp_cause_q[$];
    bit          exp_chk_q[$];
    string       exp_name_q[$];

`ifdef ANY1_PICN_NMI_EN
    localparam bit NMI_ON = 1'b1;
`else
    localparam bit NMI_ON = 1'b0;
`endif

    any1_picn #(.NSRC(32), .LVLW(4), .CAUSEW(8), .SYNC(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .ack_o(ack_o), .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i),
        .dat_o(dat_o), .src_i(src_i), .nmi_i(nmi_i), .irq_o(irq_o),
        .cause_o(cause_o), .nmi_o(nmi_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every read acknowledge against the scoreboard
    always @(negedge clk_i) begin
        if (ack_o && !we_i) begin
            if (exp_dat_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got dat_o %h expected no ack", dat_o);
            end else begin
                automatic logic [31:0] ed = exp_dat_q.pop_front();
                automatic logic [3:0]  ei = exp_irq_q.pop_front();
                automatic logic [7:0]  ec = exp_cause_q.pop_front();
                automatic bit          ek = exp_chk_q.pop_front();
                automatic string       en = exp_name_q.pop_front();
                check(en, dat_o, ed);
                if (ek) begin
                    check({en, "_irq"}, 32'(irq_o), 32'(ei));
                    check({en, "_cause"}, 32'(cause_o), 32'(ec));
                end
            end
        end
    end

    // One bus access; ack must arrive within 8 cycles and last one cycle
    task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
        bit got = 1'b0;
        @(negedge clk_i);
        cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
        we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk_i); #1;
            if (ack_o) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: got no ack expected ack for adr %h", adr);
            if (!we && exp_dat_q.size() > 0) begin
                void'(exp_dat_q.pop_back()); void'(exp_irq_q.pop_back());
                void'(exp_cause_q.pop_back()); void'(exp_chk_q.pop_back());
                void'(exp_name_q.pop_back());
            end
        end else begin
            @(posedge clk_i); #1;
            check("ack_pulse", 32'(ack_o), 32'd0);
        end
        cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
        bus(1'b1, adr, dat, 4'hF);
    endtask

    task automatic rd(input logic [7:0] adr, input logic [31:0] exp, input string nm);
        exp_dat_q.push_back(exp); exp_irq_q.push_back(4'h0); exp_cause_q.push_back(8'h0);
        exp_chk_q.push_back(1'b0); exp_name_q.push_back(nm);
        bus(1'b0, adr, 32'h0, 4'hF);
    endtask

    task automatic rd_cur(input logic [31:0] exp, input logic [3:0] irq,
                          input logic [7:0] cause, input string nm);
        exp_dat_q.push_back(exp); exp_irq_q.push_back(irq); exp_cause_q.push_back(cause);
        exp_chk_q.push_back(1'b1); exp_name_q.push_back(nm);
        bus(1'b0, 8'h10, 32'h0, 4'hF);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
    endtask

    initial begin
        idle(3);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_cause", 32'(cause_o), 32'd0);
        check("rst_nmi", 32'(nmi_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_dat", dat_o, 32'd0);

        // Every register reads 0 after reset
        rd(8'h00, 32'h0, "rst_pend");
        rd(8'h04, 32'h0, "rst_enab");
        rd(8'h08, 32'h0, "rst_edge");
        rd(8'h0C, 32'h0, "rst_clr");
        rd_cur(32'h0, 4'h0, 8'h00, "rst_cur");
        rd(8'h80, 32'h0, "rst_cfg0");
        rd(8'hFC, 32'h0, "rst_cfg31");
        wr(8'h40, 32'hFFFF_FFFF);
        rd(8'h40, 32'h0, "unmapped");

        // Level-mode source 5, level 3 cause 0x25
        wr(8'h94, 32'h0000_2503);
        wr(8'h04, 32'h0000_0020);
        rd(8'h94, 32'h0000_2503, "cfg5");
        rd(8'h04, 32'h0000_0020, "enab");
        @(posedge clk_i); #1;
        src_i[5] = 1'b1;
        idle(3);
        @(negedge clk_i);
        check("lat_early", 32'(irq_o), 32'd0);
        @(negedge clk_i);
        check("lat_irq", 32'(irq_o), 32'd3);
        check("lat_cause", 32'(cause_o), 32'h25);
        rd_cur(32'h8325_0005, 4'h3, 8'h25, "cur_src5");
        rd(8'h00, 32'h0000_0020, "pend_src5");
        src_i[5] = 1'b0;
        idle(6);
        rd_cur(32'h0025_0005, 4'h0, 8'h25, "cur_src5_drop");
        bus(1'b1, 8'h94, 32'hFFFF_FF07, 4'b0001);
        rd(8'h94, 32'h0000_2507, "cfg5_bytesel");

        // Edge-mode source 9, level 2
        wr(8'hA4, 32'h0000_0002);
        wr(8'h08, 32'h0000_0200);
        wr(8'h04, 32'h0000_0220);
        @(negedge clk_i); src_i[9] = 1'b1;
        @(negedge clk_i); src_i[9] = 1'b0;
        idle(6);
        rd(8'h00, 32'h0000_0200, "pend_edge9");
        rd_cur(32'h8200_0009, 4'h2, 8'h00, "cur_edge9");
        wr(8'h0C, 32'h0000_0200);
        idle(3);
        rd(8'h00, 32'h0000_0000, "pend_clr9");
        rd_cur(32'h0000_0009, 4'h0, 8'h00, "cur_clr9");
        // Rising edge reaches the capture stage on the same edge as the CLR write
        @(negedge clk_i); src_i[9] = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        wr(8'h0C, 32'h0000_0200);
        idle(2);
        rd(8'h00, 32'h0000_0200, "pend_set_wins");
        src_i[9] = 1'b0;
        wr(8'h0C, 32'h0000_0200);
        rd(8'h00, 32'h0000_0000, "pend_clr9b");

        // Priority ties between sources 4 and 7
        wr(8'h08, 32'h0);
        wr(8'h04, 32'h0000_0090);
        wr(8'h90, 32'h0000_4006);
        wr(8'h9C, 32'h0000_7006);
        src_i[4] = 1'b1; src_i[7] = 1'b1;
        idle(6);
        rd(8'h00, 32'h0000_0090, "pend_4_7");
        rd_cur(32'h8640_0004, 4'h6, 8'h40, "tie_low_idx");
        wr(8'h9C, 32'h0000_7007);
        idle(2);
        rd_cur(32'h8770_0007, 4'h7, 8'h70, "higher_lvl");

        // Masking by level 0 and by enable
        wr(8'h9C, 32'h0000_7000);
        idle(2);
        rd_cur(32'h8640_0004, 4'h6, 8'h40, "mask_lvl0");
        wr(8'h04, 32'h0000_0080);
        idle(2);
        rd_cur(32'h0040_0004, 4'h0, 8'h40, "mask_enab");

        // All-ones level and NMI request
        wr(8'h04, 32'h0000_0010);
        wr(8'h90, 32'h0000_400F);
        idle(2);
        rd_cur(NMI_ON ? 32'hCF40_0004 : 32'h8F40_0004, 4'hF, 8'h40, "cur_lvl15");
        @(negedge clk_i);
        check("nmi_lvl15", 32'(nmi_o), 32'(NMI_ON));
        wr(8'h04, 32'h0);
        idle(2);
        @(negedge clk_i);
        check("nmi_idle", 32'(nmi_o), 32'd0);
        nmi_i = 1'b1;
        @(negedge clk_i);
        check("nmi_ext", 32'(nmi_o), 32'(NMI_ON));
        nmi_i = 1'b0;
        src_i = 32'h0;
        idle(6);

        // Reset during a bus cycle suppresses ack
        @(negedge clk_i);
        rst_i = 1'b1;
        cs_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 8'h04;
        @(posedge clk_i); #1;
        check("rst_mid_ack", 32'(ack_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        cs_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        rd(8'h04, 32'h0, "post_rst_enab");
        rd(8'h90, 32'h0, "post_rst_cfg4");
        rd_cur(32'h0, 4'h0, 8'h00, "post_rst_cur");

        idle(4);
        check("scoreboard_empty", 32'(exp_dat_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
